// File: rtl/fp_mult_share_arbiter.sv
// Round-robin share of one enable/done floating-point multiplier among NUM_REQ requesters,
// with one-cycle ack routing of the result and a timeout abort for a hung multiplier.
module fp_mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_dataa,
  input  logic [NUM_REQ*WIDTH-1:0] req_datab,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_error,
  output logic                     busy,
  output logic [WIDTH-1:0]         mult_dataa,
  output logic [WIDTH-1:0]         mult_datab,
  output logic                     mult_enable,
  input  logic [WIDTH-1:0]         mult_result,
  input  logic                     mult_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t        state;
  logic [IW-1:0] gnt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel;
  logic          sel_valid;
  logic [TW-1:0] timer;
  int unsigned   scan_idx;

  // First asserted request scanning rr_ptr, rr_ptr+1, ... with wrap.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (rr_ptr + k) % NUM_REQ;
      if (!sel_valid && req[scan_idx]) begin
        sel       = IW'(scan_idx);
        sel_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt         <= '0;
      rr_ptr      <= '0;
      timer       <= '0;
      ack         <= '0;
      resp_result <= '0;
      resp_error  <= 1'b0;
      busy        <= 1'b0;
      mult_enable <= 1'b0;
      mult_dataa  <= '0;
      mult_datab  <= '0;
    end else begin
      ack        <= '0;
      resp_error <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            gnt         <= sel;
            rr_ptr      <= (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            mult_dataa  <= req_dataa[sel*WIDTH +: WIDTH];
            mult_datab  <= req_datab[sel*WIDTH +: WIDTH];
            mult_enable <= 1'b1;
            timer       <= '0;
            busy        <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          timer <= timer + 1'b1;
          // Done takes priority over a timeout landing on the same cycle.
          if (mult_done) begin
            resp_result <= mult_result;
            ack[gnt]    <= 1'b1;
            mult_enable <= 1'b0;
            state       <= RELEASE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            resp_result <= '0;
            ack[gnt]    <= 1'b1;
            resp_error  <= 1'b1;
            mult_enable <= 1'b0;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          // Hold off the next issue until the multiplier drops done and re-arms.
          if (!mult_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
